// File: rtl/ps2_rx_pkg.sv
// Purpose: shared types and constants for the PS/2 host receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    // start + 8 data + parity + stop
    localparam int FRAME_BITS     = 11;
    localparam int DATA_BITS      = FRAME_BITS - 3;
    localparam int DEF_FILTER_LEN = 4;
    localparam int DEF_TIMEOUT    = 20000;

    // Odd parity over data plus parity bit: total count of ones must be odd.
    function automatic logic odd_parity_ok(input logic [7:0] dat, input logic par);
        return ^{dat, par};
    endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Purpose: 2-flop synchroniser plus FILTER_LEN-sample agreement filter for one PS/2 line.
// Latency: pin change to line_filt change is FILTER_LEN+3 clk_sys edges.
// Backpressure: none; free-running.
// Ports: clk_sys/reset_n clock and async active-low reset, line_in raw asynchronous
//        line, line_filt deglitched line (resets high, the PS/2 idle level).
module ps2_sync_filter
    import ps2_rx_pkg::*;
#(
    parameter int FILTER_LEN = DEF_FILTER_LEN
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic line_in,
    output logic line_filt
);

    logic [1:0]            sync_q,  sync_d;
    logic [FILTER_LEN-1:0] shift_q, shift_d;
    logic                  filt_q,  filt_d;

    always_comb begin
        sync_d  = {sync_q[0], line_in};
        shift_d = {shift_q[FILTER_LEN-2:0], sync_q[1]};
        filt_d  = filt_q;
        // Only a unanimous window moves the output; anything shorter is a glitch.
        if (&shift_q) begin
            filt_d = 1'b1;
        end else if (~|shift_q) begin
            filt_d = 1'b0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '1;
            shift_q <= '1;
            filt_q  <= 1'b1;
        end else begin
            sync_q  <= sync_d;
            shift_q <= shift_d;
            filt_q  <= filt_d;
        end
    end

    assign line_filt = filt_q;

endmodule

// File: rtl/ps2_host_rx.sv
// Purpose: PS/2 host receiver: conditions clk/data, deframes 11-bit frames, buffers bytes in a FWFT FIFO.
// Latency: pin fall of the stop bit to rx_valid is FILTER_LEN+4 clk_sys edges.
// Backpressure: rx_ready stalls the FIFO head; a byte arriving while full is dropped and overflow pulses.
// Ports: clk_sys/reset_n clock and async active-low reset; ps2_clk/ps2_data raw lines;
//        rx_data/rx_valid/rx_ready output stream; frame_err/overflow one-cycle pulses;
//        err_count saturating error count; fifo_level entries held.
module ps2_host_rx
    import ps2_rx_pkg::*;
#(
    parameter int FILTER_LEN = DEF_FILTER_LEN,
    parameter int FIFO_BITS  = 3,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic                 ps2_clk,
    input  logic                 ps2_data,
    output logic [7:0]           rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overflow,
    output logic [7:0]           err_count,
    output logic [FIFO_BITS:0]   fifo_level
);

    localparam int                 DEPTH    = 1 << FIFO_BITS;
    localparam logic [FIFO_BITS:0] LVL_FULL = (FIFO_BITS+1)'(DEPTH);
    localparam logic [FIFO_BITS:0] LVL_ONE  = (FIFO_BITS+1)'(1);
    localparam logic [FIFO_BITS-1:0] PTR_ONE = FIFO_BITS'(1);
    localparam logic [15:0]        TMO_LAST = 16'(TIMEOUT - 1);
    localparam logic [2:0]         BIT_LAST = 3'(DATA_BITS - 1);

    logic filt_clk, filt_data;

    // Identical conditioning on both lines keeps data aligned with the clock edge.
    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_clk (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .line_in   (ps2_clk),
        .line_filt (filt_clk)
    );

    ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_data (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .line_in   (ps2_data),
        .line_filt (filt_data)
    );

    logic                 filt_clk_prev_q, filt_clk_prev_d;
    rx_state_e            state_q,     state_d;
    logic [2:0]           bitcnt_q,    bitcnt_d;
    logic [7:0]           shreg_q,     shreg_d;
    logic                 parity_q,    parity_d;
    logic [15:0]          tmo_q,       tmo_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overflow_q,  overflow_d;
    logic [7:0]           err_cnt_q,   err_cnt_d;
    logic [FIFO_BITS-1:0] wr_ptr_q,    wr_ptr_d;
    logic [FIFO_BITS-1:0] rd_ptr_q,    rd_ptr_d;
    logic [FIFO_BITS:0]   level_q,     level_d;
    logic [7:0]           mem_q [DEPTH];
    logic [7:0]           mem_d [DEPTH];

    logic fall, push_req, err_pulse, push, pop, full;

    assign fall = filt_clk_prev_q & ~filt_clk;
    assign full = (level_q == LVL_FULL);
    assign pop  = (level_q != '0) & rx_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still take the byte.
    assign push = push_req & (~full | pop);

    always_comb begin
        filt_clk_prev_d = filt_clk;
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        shreg_d   = shreg_q;
        parity_d  = parity_q;
        push_req  = 1'b0;
        err_pulse = 1'b0;

        if (fall) begin
            unique case (state_q)
                IDLE: begin
                    if (!filt_data) begin
                        state_d  = DATA;
                        bitcnt_d = '0;
                    end
                end
                DATA: begin
                    shreg_d  = {filt_data, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == BIT_LAST) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    parity_d = filt_data;
                    state_d  = STOP;
                end
                STOP: begin
                    if (filt_data && odd_parity_ok(shreg_q, parity_q)) begin
                        push_req = 1'b1;
                    end else begin
                        err_pulse = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && tmo_q == TMO_LAST) begin
            // Abort lands on the cycle the idle count reaches TIMEOUT.
            state_d   = IDLE;
            err_pulse = 1'b1;
            shreg_d   = '0;
        end

        tmo_d = (fall || state_q == IDLE) ? '0 : tmo_q + 16'd1;

        frame_err_d = err_pulse;
        err_cnt_d   = (err_pulse && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
        overflow_d  = push_req & full & ~pop;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = shreg_q;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LVL_ONE;
        end else if (!push && pop) begin
            level_d = level_q - LVL_ONE;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            filt_clk_prev_q <= 1'b1;
            state_q     <= IDLE;
            bitcnt_q    <= '0;
            shreg_q     <= '0;
            parity_q    <= 1'b0;
            tmo_q       <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            err_cnt_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            mem_q       <= '{default: '0};
        end else begin
            filt_clk_prev_q <= filt_clk_prev_d;
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shreg_q     <= shreg_d;
            parity_q    <= parity_d;
            tmo_q       <= tmo_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
            err_cnt_q   <= err_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            mem_q       <= mem_d;
        end
    end

    assign rx_valid   = (level_q != '0);
    // Head is held by rd_ptr, so it cannot move until the consumer pops.
    assign rx_data    = rx_valid ? mem_q[rd_ptr_q] : '0;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;
    assign err_count  = err_cnt_q;
    assign fifo_level = level_q;

endmodule

// File: tb/tb_ps2_host_rx.sv
// Purpose: self-checking bench for ps2_host_rx with randomized frames and a byte-queue reference model.
// Latency: checks the stop-fall to rx_valid latency and the timeout abort cycle exactly.
// Backpressure: exercises rx_ready low (overflow) and random rx_ready draining.
module tb_ps2_host_rx;

    localparam int FL  = 4;
    localparam int TMO = 20000;

    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overflow;
    logic [7:0] err_count;
    logic [3:0] fifo_level;

    ps2_host_rx #(.FILTER_LEN(FL), .FIFO_BITS(3), .TIMEOUT(TMO)) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .err_count  (err_count),
        .fifo_level (fifo_level)
    );

    initial forever #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    // Reference model: bytes expected out of the FIFO in order, plus event counts.
    logic [7:0] exp_q[$];
    int exp_err = 0, exp_ovf = 0;

    int n_chk = 0, n_pass = 0;
    int err_seen = 0, ovf_seen = 0, n_pop = 0, valid_cycles = 0;
    int last_err_cyc = 0, valid_rise_cyc = 0, last_fall = 0;
    bit valid_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    // Frame judged purely from the protocol rules: stop high and odd ones over data+parity.
    task automatic predict(input logic [10:0] f);
        int ones;
        ones = 0;
        for (int k = 1; k <= 9; k++) ones += int'(f[k]);
        if (f[10] == 1'b1 && (ones % 2) == 1) begin
            if (exp_q.size() >= 8) exp_ovf++;
            else exp_q.push_back(f[8:1]);
        end else begin
            exp_err++;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop_v,
                              input int nbits, input int hp, input bit glitch);
        logic [10:0] f;
        f = {stop_v, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            if (glitch) begin
                tick(hp / 2);
                ps2_clk = 1'b0;
                tick(FL - 1);
                ps2_clk = 1'b1;
                tick(hp - hp / 2 - (FL - 1));
            end else begin
                tick(hp);
            end
            ps2_clk = 1'b0;
            last_fall = cyc;
            if (i == 10) predict(f);
            tick(hp);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        tick(2 * hp);
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_rx_data"},    32'(rx_data),    32'd0);
        chk({pfx, "_rx_valid"},   32'(rx_valid),   32'd0);
        chk({pfx, "_frame_err"},  32'(frame_err),  32'd0);
        chk({pfx, "_overflow"},   32'(overflow),   32'd0);
        chk({pfx, "_err_count"},  32'(err_count),  32'd0);
        chk({pfx, "_fifo_level"}, 32'(fifo_level), 32'd0);
    endtask

    // Monitor samples just after the negedge, once stimulus for the next posedge is settled.
    always @(negedge clk_sys) begin
        #2;
        if (reset_n) begin
            if (frame_err) begin
                err_seen++;
                last_err_cyc = cyc;
            end
            if (overflow) ovf_seen++;
            if (rx_valid) begin
                valid_cycles++;
                if (!valid_prev) valid_rise_cyc = cyc;
            end
            if (rx_valid && rx_ready) begin
                n_pop++;
                if (exp_q.size() != 0) chk("pop_data", 32'(rx_data), 32'(exp_q.pop_front()));
                else chk("pop_unexpected", 32'(rx_data), 32'h100);
            end
        end
        valid_prev = rx_valid;
    end

    initial begin
        #1_200_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int p0, v0, e0;
        int b, kind, hp;

        // Reset values while reset_n is held low.
        tick(3);
        chk_reset_outputs("rst");
        reset_n = 1'b1;
        tick(5);

        // Single good frame at PS2DIV=1000, exact latency and one-cycle valid.
        p0 = n_pop; v0 = valid_cycles;
        send_frame(8'h1C, 1'b0, 1'b1, 11, 1000, 1'b0);
        chk("t1_latency",   32'(valid_rise_cyc - last_fall), 32'(FL + 4));
        chk("t1_valid_len", 32'(valid_cycles - v0), 32'd1);
        chk("t1_pops",      32'(n_pop - p0), 32'd1);
        chk("t1_no_err",    32'(err_seen), 32'd0);

        // Parity error then stop-bit error.
        send_frame(8'h1C, 1'b1, 1'b1, 11, 20, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0, 11, 20, 1'b0);
        chk("t2_err_pulses", 32'(err_seen), 32'(exp_err));
        chk("t2_err_count",  32'(err_count), 32'd2);
        chk("t2_fifo_empty", 32'(fifo_level), 32'd0);
        chk("t2_no_valid",   32'(rx_valid), 32'd0);

        // Fill with rx_ready low: ninth byte overflows.
        rx_ready = 1'b0;
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1, 11, 20, 1'b0);
        chk("t3_level_full", 32'(fifo_level), 32'd8);
        chk("t3_ovf_pulses", 32'(ovf_seen), 32'(exp_ovf));
        chk("t3_ovf_one",    32'(ovf_seen), 32'd1);
        chk("t3_head",       32'(rx_data), 32'h01);
        p0 = n_pop;
        for (int k = 0; k < 400 && rx_valid; k++) begin
            rx_ready = 1'($urandom_range(0, 1));
            tick(1);
        end
        rx_ready = 1'b1;
        tick(2);
        chk("t3_drain_pops",  32'(n_pop - p0), 32'd8);
        chk("t3_drain_level", 32'(fifo_level), 32'd0);
        chk("t3_model_empty", 32'(exp_q.size()), 32'd0);

        // Timeout after start + 5 data bits, then a clean frame.
        e0 = err_seen;
        send_frame(8'h5A, 1'b0, 1'b1, 6, 20, 1'b0);
        for (int k = 0; k < TMO + 200 && err_seen == e0; k++) tick(1);
        exp_err++;
        chk("t4_tmo_err",   32'(err_seen - e0), 32'd1);
        chk("t4_tmo_cycle", 32'(last_err_cyc - last_fall), 32'(FL + 4 + TMO));
        p0 = n_pop;
        send_frame(8'h5A, 1'b0, 1'b1, 11, 20, 1'b0);
        chk("t4_after_pop", 32'(n_pop - p0), 32'd1);

        // Clock glitches shorter than the filter, idle (data low) and mid-frame.
        e0 = err_seen; p0 = n_pop;
        ps2_data = 1'b0;
        tick(10);
        ps2_clk = 1'b0; tick(FL - 1); ps2_clk = 1'b1;
        tick(10);
        ps2_data = 1'b1;
        tick(20);
        send_frame(8'hA5, 1'b0, 1'b1, 11, 20, 1'b1);
        chk("t5_no_err", 32'(err_seen - e0), 32'd0);
        chk("t5_pop",    32'(n_pop - p0), 32'd1);

        // Randomized frames with random timing, errors and glitches.
        for (int i = 0; i < 10; i++) begin
            b    = int'($urandom_range(0, 255));
            kind = int'($urandom_range(0, 4));
            hp   = int'($urandom_range(10, 24));
            send_frame(8'(b), kind == 3, kind != 4, 11, hp, 1'($urandom_range(0, 1)));
        end
        tick(10);
        chk("rnd_err_pulses", 32'(err_seen), 32'(exp_err));
        chk("rnd_err_count",  32'(err_count), 32'(exp_err > 255 ? 255 : exp_err));
        chk("rnd_ovf",        32'(ovf_seen), 32'(exp_ovf));
        chk("rnd_model_empty", 32'(exp_q.size()), 32'd0);

        // Reset mid-frame with a byte buffered and a nonzero error count.
        rx_ready = 1'b0;
        send_frame(8'h33, 1'b0, 1'b1, 11, 20, 1'b0);
        send_frame(8'h44, 1'b0, 1'b1, 5, 20, 1'b0);
        chk("t6_pre_level", 32'(fifo_level), 32'd1);
        reset_n = 1'b0;
        tick(2);
        chk_reset_outputs("t6_rst");
        exp_q.delete();
        exp_err = 0; exp_ovf = 0; err_seen = 0; ovf_seen = 0;
        reset_n = 1'b1;
        rx_ready = 1'b1;
        tick(5);
        p0 = n_pop;
        send_frame(8'h76, 1'b0, 1'b1, 11, 20, 1'b0);
        chk("t6_pop",       32'(n_pop - p0), 32'd1);
        chk("t6_err_count", 32'(err_count), 32'd0);
        chk("t6_err_seen",  32'(err_seen), 32'd0);
        chk("t6_level",     32'(fifo_level), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
